// File: rtl/vend_pkg.sv
// Shared definitions for the vending dispenser: response codes, FSM states
// and the id width used on the request, motor and service ports.
package vend_pkg;

    localparam int ID_W = 4;

    localparam logic [1:0] VEND_OK    = 2'b00;
    localparam logic [1:0] VEND_EMPTY = 2'b01;
    localparam logic [1:0] VEND_JAM   = 2'b10;
    localparam logic [1:0] VEND_BADID = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_DRIVE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } vend_state_t;

endpackage

// File: rtl/vend_sync_edge.sv
// Two-flop synchronizer for an asynchronous panel input followed by a
// rising-edge detector; rise is a single-cycle pulse per low-to-high edge.
module vend_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise
);

    logic meta;
    logic sync;
    logic prev;

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge value; blocking here would collapse the chain into one flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= async_in;
            sync <= meta;
            prev <= sync;
        end
    end

    assign rise = sync & ~prev;

endmodule

// File: rtl/vend_dispenser.sv
// Dispense-side responder: validates a slot request, pulses the slot motor
// with bounded retries, confirms delivery on the drop sensor and owns stock.
module vend_dispenser
    import vend_pkg::*;
#(
    parameter int SLOTS       = 16,
    parameter int CNT_W       = 4,
    parameter int MOTOR_CYC   = 8,
    parameter int TIMEOUT_CYC = 32,
    parameter int MAX_RETRY   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [ID_W-1:0]  req_id,
    output logic             req_ready,
    output logic             rsp_valid,
    output logic [1:0]       rsp_code,
    output logic             motor_on,
    output logic [ID_W-1:0]  motor_sel,
    input  logic             drop_sense,
    input  logic             restock_en,
    input  logic [ID_W-1:0]  restock_id,
    input  logic [CNT_W-1:0] restock_cnt,
    output logic [SLOTS-1:0] stock_empty
);

    localparam int TMR_MAX = (MOTOR_CYC > TIMEOUT_CYC) ? MOTOR_CYC : TIMEOUT_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] MOTOR_LAST  = TMR_W'(MOTOR_CYC - 1);
    localparam logic [TMR_W-1:0] WAIT_LAST   = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [1:0]       RETRY_LIMIT = 2'(MAX_RETRY);

    vend_state_t      state;
    vend_state_t      state_nxt;
    logic [TMR_W-1:0] tmr;
    logic [TMR_W-1:0] tmr_nxt;
    logic [1:0]       retry;
    logic [1:0]       retry_nxt;
    logic [1:0]       code_q;
    logic [1:0]       code_nxt;
    logic [ID_W-1:0]  id_q;
    logic             dec_en;
    logic             drop_evt;
    logic             id_valid;
    logic [CNT_W-1:0] sel_count;

    logic [CNT_W-1:0] count [SLOTS];

    vend_sync_edge u_drop_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (drop_sense),
        .rise     (drop_evt)
    );

    assign id_valid  = (int'(id_q) < SLOTS);
    assign sel_count = id_valid ? count[id_q] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            tmr    <= '0;
            retry  <= '0;
            code_q <= VEND_OK;
            id_q   <= '0;
        end else begin
            state  <= state_nxt;
            tmr    <= tmr_nxt;
            retry  <= retry_nxt;
            code_q <= code_nxt;
            if (state == ST_IDLE && req_valid) begin
                id_q <= req_id;
            end
        end
    end

    // NOTE: every signal driven here gets its hold value first, so no branch
    // of the case can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        retry_nxt = retry;
        code_nxt  = code_q;
        dec_en    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    state_nxt = ST_CHECK;
                end
            end

            ST_CHECK: begin
                if (!id_valid) begin
                    code_nxt  = VEND_BADID;
                    state_nxt = ST_RESP;
                end else if (sel_count == '0) begin
                    code_nxt  = VEND_EMPTY;
                    state_nxt = ST_RESP;
                end else begin
                    tmr_nxt   = '0;
                    retry_nxt = '0;
                    state_nxt = ST_DRIVE;
                end
            end

            // An early drop while the motor still runs is a real delivery.
            ST_DRIVE: begin
                if (drop_evt) begin
                    dec_en    = 1'b1;
                    code_nxt  = VEND_OK;
                    state_nxt = ST_RESP;
                end else if (tmr == MOTOR_LAST) begin
                    tmr_nxt   = '0;
                    state_nxt = ST_WAIT;
                end else begin
                    tmr_nxt = tmr + TMR_W'(1);
                end
            end

            ST_WAIT: begin
                if (drop_evt) begin
                    dec_en    = 1'b1;
                    code_nxt  = VEND_OK;
                    state_nxt = ST_RESP;
                end else if (tmr == WAIT_LAST) begin
                    tmr_nxt = '0;
                    if (retry < RETRY_LIMIT) begin
                        retry_nxt = retry + 2'd1;
                        state_nxt = ST_DRIVE;
                    end else begin
                        code_nxt  = VEND_JAM;
                        state_nxt = ST_RESP;
                    end
                end else begin
                    tmr_nxt = tmr + TMR_W'(1);
                end
            end

            ST_RESP: begin
                state_nxt = ST_IDLE;
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // NOTE: the stock file is ordinary flops with reset, not RAM, because every
    // slot must read as empty out of reset and all counts feed stock_empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SLOTS; i++) begin
                count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SLOTS; i++) begin
                if (restock_en && int'(restock_id) == i) begin
                    count[i] <= restock_cnt;
                end else if (dec_en && int'(id_q) == i && count[i] != '0) begin
                    count[i] <= count[i] - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stock_empty <= '1;
        end else begin
            for (int i = 0; i < SLOTS; i++) begin
                stock_empty[i] <= (count[i] == '0);
            end
        end
    end

    // Outputs decode straight from the state flops so reset kills the motor
    // without waiting for a clock edge.
    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign motor_on  = (state == ST_DRIVE);
    assign rsp_code  = code_q;
    assign motor_sel = id_q;

endmodule

// File: tb/tb_vend_dispenser.sv
// Directed bench for vend_dispenser: restock, vend with and without drops,
// retries, bad ids, restock/decrement collision, held sensor and reset abort.
module tb_vend_dispenser;
    import vend_pkg::*;

    localparam int SLOTS       = 10;
    localparam int CNT_W       = 4;
    localparam int MOTOR_CYC   = 8;
    localparam int TIMEOUT_CYC = 32;
    localparam int MAX_RETRY   = 1;
    localparam int JAM_LAT     = 2 + (MAX_RETRY + 1) * (MOTOR_CYC + TIMEOUT_CYC);

    logic             clk         = 1'b0;
    logic             reset       = 1'b1;
    logic             req_valid   = 1'b0;
    logic [3:0]       req_id      = '0;
    logic             drop_sense  = 1'b0;
    logic             restock_en  = 1'b0;
    logic [3:0]       restock_id  = '0;
    logic [CNT_W-1:0] restock_cnt = '0;
    logic             req_ready;
    logic             rsp_valid;
    logic [1:0]       rsp_code;
    logic             motor_on;
    logic [3:0]       motor_sel;
    logic [SLOTS-1:0] stock_empty;
    logic [SLOTS-1:0] exp_empty = '1;

    int cyc     = 0;
    int t_acc   = 0;
    int n_pass  = 0;
    int n_total = 0;
    int seen    = 0;

    always #5 clk = ~clk;

    vend_dispenser #(
        .SLOTS       (SLOTS),
        .CNT_W       (CNT_W),
        .MOTOR_CYC   (MOTOR_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .MAX_RETRY   (MAX_RETRY)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_id      (req_id),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_code    (rsp_code),
        .motor_on    (motor_on),
        .motor_sel   (motor_sel),
        .drop_sense  (drop_sense),
        .restock_en  (restock_en),
        .restock_id  (restock_id),
        .restock_cnt (restock_cnt),
        .stock_empty (stock_empty)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic restock(input logic [3:0] id, input logic [CNT_W-1:0] c);
        restock_en  = 1'b1;
        restock_id  = id;
        restock_cnt = c;
        tick();
        restock_en  = 1'b0;
    endtask

    // Leaves cyc = T+1 (CHECK), with T the accept cycle.
    task automatic accept(input logic [3:0] id);
        req_valid = 1'b1;
        req_id    = id;
        tick();
        req_valid = 1'b0;
        t_acc     = cyc - 1;
    endtask

    // Sensor high for two cycles from cycle c; the edge reaches the FSM in c+2.
    task automatic drop_at(input int c);
        run_to(c);
        drop_sense = 1'b1;
        tick();
        tick();
        drop_sense = 1'b0;
    endtask

    task automatic expect_jam(input logic [3:0] id, input string tag);
        int bad_motor = 0;
        int bad_sel   = 0;
        int early     = 0;
        while (cyc < t_acc + JAM_LAT) begin
            logic exp_m;
            exp_m = 1'b0;
            for (int r = 0; r <= MAX_RETRY; r++) begin
                int s;
                s = t_acc + 2 + r * (MOTOR_CYC + TIMEOUT_CYC);
                if (cyc >= s && cyc < s + MOTOR_CYC) exp_m = 1'b1;
            end
            if (motor_on !== exp_m) bad_motor++;
            if (motor_sel !== id) bad_sel++;
            if (rsp_valid !== 1'b0) early++;
            tick();
        end
        check({tag, "_motor_pattern"}, bad_motor, 0);
        check({tag, "_motor_sel"}, bad_sel, 0);
        check({tag, "_no_early_rsp"}, early, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 1);
        check({tag, "_rsp_code"}, rsp_code, VEND_JAM);
        tick();
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_code", rsp_code, VEND_OK);
        check("rst_motor_on", motor_on, 0);
        check("rst_motor_sel", motor_sel, 0);
        check("rst_stock_empty", stock_empty, {SLOTS{1'b1}});

        // Slot 3 with two items: two good vends, then empty.
        restock(4'd3, 4'd2);
        tick();
        exp_empty[3] = 1'b0;
        check("t1_empty_after_restock", stock_empty, exp_empty);
        accept(4'd3);
        run_to(t_acc + 2);
        check("t1_motor_on", motor_on, 1);
        check("t1_motor_sel", motor_sel, 3);
        run_to(t_acc + 10);
        check("t1_motor_off", motor_on, 0);
        drop_at(t_acc + 15);
        check("t1_no_early_rsp", rsp_valid, 0);
        tick();
        check("t1_ok_valid", rsp_valid, 1);
        check("t1_ok_code", rsp_code, VEND_OK);
        tick();
        check("t1_still_stocked", stock_empty, exp_empty);
        check("t1_ready_again", req_ready, 1);

        accept(4'd3);
        drop_at(t_acc + 15);
        tick();
        check("t1b_ok_valid", rsp_valid, 1);
        check("t1b_ok_code", rsp_code, VEND_OK);
        tick();
        exp_empty[3] = 1'b1;
        check("t1b_now_empty", stock_empty, exp_empty);

        accept(4'd3);
        check("t1c_motor_t1", motor_on, 0);
        check("t1c_no_rsp_t1", rsp_valid, 0);
        tick();
        check("t1c_empty_valid", rsp_valid, 1);
        check("t1c_empty_code", rsp_code, VEND_EMPTY);
        check("t1c_motor_t2", motor_on, 0);
        tick();

        // Slot 5, no drop at all: two motor pulses then JAM, stock kept.
        restock(4'd5, 4'd1);
        exp_empty[5] = 1'b0;
        accept(4'd5);
        expect_jam(4'd5, "t2");
        check("t2_count5", dut.count[5], 1);

        // Slot 7: first attempt times out, drop during the retry wait.
        restock(4'd7, 4'd4);
        exp_empty[7] = 1'b0;
        accept(4'd7);
        run_to(t_acc + 42);
        check("t3_retry_motor", motor_on, 1);
        drop_at(t_acc + 52);
        check("t3_no_early_rsp", rsp_valid, 0);
        tick();
        check("t3_ok_valid", rsp_valid, 1);
        check("t3_ok_code", rsp_code, VEND_OK);
        check("t3_count7", dut.count[7], 3);
        tick();

        // Out-of-range ids: vend and restock.
        accept(4'd12);
        tick();
        check("t4_badid_valid", rsp_valid, 1);
        check("t4_badid_code", rsp_code, VEND_BADID);
        tick();
        accept(4'd10);
        tick();
        check("t4_badid10_code", rsp_code, VEND_BADID);
        tick();
        restock(4'd12, 4'd5);
        tick();
        check("t4_restock_ignored", stock_empty, exp_empty);

        // Slot 2: restock lands in the same cycle as the OK decrement.
        restock(4'd2, 4'd1);
        exp_empty[2] = 1'b0;
        accept(4'd2);
        run_to(t_acc + 12);
        drop_sense = 1'b1;
        tick();
        tick();
        restock_en  = 1'b1;
        restock_id  = 4'd2;
        restock_cnt = 4'd9;
        check("t5_no_early_rsp", rsp_valid, 0);
        tick();
        restock_en = 1'b0;
        check("t5_ok_valid", rsp_valid, 1);
        check("t5_ok_code", rsp_code, VEND_OK);
        check("t5_restock_wins", dut.count[2], 9);
        tick();
        tick();
        check("t5_stocked", stock_empty, exp_empty);
        accept(4'd2);
        expect_jam(4'd2, "t5_held");
        check("t5_count2_kept", dut.count[2], 9);
        drop_sense = 1'b0;

        // Reset while the motor runs.
        restock(4'd4, 4'd3);
        accept(4'd4);
        run_to(t_acc + 4);
        check("t6_motor_before", motor_on, 1);
        reset = 1'b1;
        #1;
        check("t6_motor_async_off", motor_on, 0);
        check("t6_no_rsp", rsp_valid, 0);
        tick();
        tick();
        reset = 1'b0;
        check("t6_ready", req_ready, 1);
        check("t6_all_empty", stock_empty, {SLOTS{1'b1}});
        check("t6_motor_sel", motor_sel, 0);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid !== 1'b0 || motor_on !== 1'b0) seen++;
            tick();
        end
        check("t6_quiet_after", seen, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
